// File: rtl/tt_scan_pkg.sv
// Shared types and sizing helpers for the truth-table scanner.
package tt_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned N_IN_DEF = 3;
    localparam int unsigned ROWS     = 2 ** N_IN_DEF;

    // Settle counter must hold 0..settle; never narrower than one bit.
    function automatic int unsigned settle_cnt_w(input int unsigned settle);
        return (settle < 2) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/tt_first_mismatch.sv
// Priority encoder locating the lowest row where the captured mask
// disagrees with the expected mask.
module tt_first_mismatch
    import tt_scan_pkg::*;
#(
    parameter int unsigned N_IN = 3
) (
    input  logic [2**N_IN-1:0] mask,
    input  logic [2**N_IN-1:0] exp_mask,
    output logic               any_err,
    output logic [N_IN-1:0]    first_err
);

    logic [2**N_IN-1:0] diff;

    // Scan high to low so the lowest differing index is written last.
    always_comb begin
        diff      = mask ^ exp_mask;
        any_err   = |diff;
        first_err = '0;
        for (int unsigned i = 2 ** N_IN; i > 0; i--) begin
            if (diff[i-1]) first_err = N_IN'(i - 1);
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps every input row of a combinational function, captures its
// minterm mask after a settle delay and compares it to an expected mask.
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int unsigned         N_IN   = 3,
    parameter int unsigned         SETTLE = 1,
    parameter logic [2**N_IN-1:0]  EXPECT = 8'b1100_1010
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               s_in,
    output logic [N_IN-1:0]    vec,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2**N_IN-1:0] mask,
    output logic [N_IN-1:0]    first_err
);

    localparam int unsigned ROWS_L = 2 ** N_IN;
    localparam int unsigned CW     = settle_cnt_w(SETTLE);

    state_t          state;
    logic [N_IN-1:0] row;
    logic [CW-1:0]   cnt;
    logic            any_err;
    logic [N_IN-1:0] fe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
            cnt   <= '0;
            mask  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        row   <= '0;
                        cnt   <= '0;
                        mask  <= '0;
                    end
                end
                RUN: begin
                    if (cnt == CW'(SETTLE)) begin
                        mask[row] <= s_in;
                        cnt       <= '0;
                        // row stays at the last index in DONE so vec holds all ones
                        if (row == N_IN'(ROWS_L - 1)) state <= DONE;
                        else                          row   <= row + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    tt_first_mismatch #(
        .N_IN (N_IN)
    ) u_first_mismatch (
        .mask      (mask),
        .exp_mask  (EXPECT),
        .any_err   (any_err),
        .first_err (fe)
    );

    assign vec       = row;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign pass      = done & ~any_err;
    assign first_err = done ? fe : '0;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized self-checking bench for truth_table_scanner (SETTLE=1 and SETTLE=0 instances).
module tb_truth_table_scanner;

    localparam logic [7:0] EXP = 8'hCA;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] tbl0 = 8'hCA, tbl1 = 8'hCA;
    logic       s0, s1;
    logic [2:0] vec0, vec1, fe0, fe1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [7:0] mask0, mask1;

    logic       sel = 1'b0;
    logic [2:0] o_vec, o_fe;
    logic       o_busy, o_done, o_pass;
    logic [7:0] o_mask;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Function under test is a lookup table indexed by the applied row.
    assign s0 = tbl0[vec0];
    assign s1 = tbl1[vec1];

    assign o_vec  = sel ? vec1  : vec0;
    assign o_fe   = sel ? fe1   : fe0;
    assign o_busy = sel ? busy1 : busy0;
    assign o_done = sel ? done1 : done0;
    assign o_pass = sel ? pass1 : pass0;
    assign o_mask = sel ? mask1 : mask0;

    truth_table_scanner #(.N_IN(3), .SETTLE(1), .EXPECT(8'hCA)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .s_in(s0), .vec(vec0), .busy(busy0),
        .done(done0), .pass(pass0), .mask(mask0), .first_err(fe0)
    );

    truth_table_scanner #(.N_IN(3), .SETTLE(0), .EXPECT(8'hCA)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .s_in(s1), .vec(vec1), .busy(busy1),
        .done(done1), .pass(pass1), .mask(mask1), .first_err(fe1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_first(input logic [7:0] tbl);
        for (int i = 0; i < 8; i++)
            if (tbl[i] != EXP[i]) return 3'(i);
        return 3'd0;
    endfunction

    task automatic check_idle(input string tag);
        check_val({tag, "_vec0"},  vec0,  0);
        check_val({tag, "_mask0"}, mask0, 0);
        check_val({tag, "_busy0"}, busy0, 0);
        check_val({tag, "_done0"}, done0, 0);
        check_val({tag, "_pass0"}, pass0, 0);
        check_val({tag, "_fe0"},   fe0,   0);
        check_val({tag, "_vec1"},  vec1,  0);
        check_val({tag, "_mask1"}, mask1, 0);
        check_val({tag, "_busy1"}, busy1, 0);
        check_val({tag, "_done1"}, done1, 0);
    endtask

    // One full sweep; start is re-pulsed at edges inj_a/inj_b (must be ignored).
    task automatic run_sweep(input bit s, input logic [7:0] tbl, input int inj_a, input int inj_b);
        int per;
        int total;
        per   = s ? 1 : 2;
        total = 8 * per;
        sel   = s;
        if (s) tbl1 = tbl; else tbl0 = tbl;
        if (s) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        check_val("e0_busy", o_busy, 1);
        check_val("e0_vec",  o_vec,  0);
        check_val("e0_done", o_done, 0);
        check_val("e0_pass", o_pass, 0);
        check_val("e0_mask", o_mask, 0);
        for (int k = 1; k <= total; k++) begin
            @(posedge clk); #1;
            start0 = 1'b0; start1 = 1'b0;
            if (k < total) begin
                check_val("run_busy", o_busy, 1);
                check_val("run_vec",  o_vec,  k / per);
                check_val("run_done", o_done, 0);
                if (k + 1 == inj_a || k + 1 == inj_b) begin
                    if (s) start1 = 1'b1; else start0 = 1'b1;
                end
            end else begin
                check_val("fin_done", o_done, 1);
                check_val("fin_busy", o_busy, 0);
                check_val("fin_vec",  o_vec,  7);
                check_val("fin_mask", o_mask, tbl);
                check_val("fin_pass", o_pass, tbl == EXP);
                check_val("fin_fe",   o_fe,   model_first(tbl));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random start/s_in activity.
        rst = 1'b1;
        repeat (2) begin
            start0 = 1'($urandom); start1 = 1'($urandom);
            tbl0 = 8'($urandom);   tbl1 = 8'($urandom);
            @(posedge clk); #1;
        end
        check_idle("rst");

        // rst and start together: rst wins.
        start0 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
        check_idle("rst_start");
        @(posedge clk); #1;
        check_idle("post_rst");

        run_sweep(0, EXP, -1, -1);       // golden fxy
        run_sweep(0, 8'h00, -1, -1);     // s_in tied 0
        run_sweep(0, 8'h35, -1, -1);     // inverted fxy
        run_sweep(0, EXP, 3, 9);         // start during RUN ignored
        run_sweep(0, EXP, -1, -1);       // restart straight from DONE

        // Reset at edge 7 of a sweep.
        sel = 1'b0;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("mid_rst");
        run_sweep(0, EXP, -1, -1);

        run_sweep(1, 8'hFF, -1, -1);     // SETTLE=0, s_in tied 1
        run_sweep(1, EXP, -1, -1);

        for (int i = 0; i < 6; i++) begin
            run_sweep(0, 8'($urandom), -1, -1);
            run_sweep(1, 8'($urandom), -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
